// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: walks a 16-bit adder over WORDS slices, LSW first.
// Optional subtract mode is compiled in with `define MP_ADD_SEQ_SUB_EN (adds port in_sub).
module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout
);

  localparam int N  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          carry_reg, carry_next;
  logic          cout_reg, cout_next;
  logic [N-1:0]  a_reg, a_next;
  logic [N-1:0]  b_reg, b_next;
  logic [N-1:0]  sum_reg, sum_next;
  logic          run;
  logic          sub_sel;

  logic [15:0]   a_slice [WORDS];
  logic [15:0]   b_slice [WORDS];

`ifdef MP_ADD_SEQ_SUB_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign run = (state_reg == RUN);

  // Only the slice addressed by idx is overwritten; the rest hold.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[16*gi +: 16];
      assign b_slice[gi] = b_reg[16*gi +: 16];
      assign sum_next[16*gi +: 16] = (run && idx_reg == IW'(gi)) ? add_sum
                                                                 : sum_reg[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = in_a;
          // Subtract is A + ~B + 1, so the carry-out reads as "no borrow".
          b_next     = sub_sel ? ~in_b : in_b;
          carry_next = sub_sel ? 1'b1 : in_cin;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        carry_next = add_cout;
        if (idx_reg == LAST_IDX) begin
          cout_next  = add_cout;
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign add_a     = run ? a_slice[idx_reg] : 16'h0000;
  assign add_b     = run ? b_slice[idx_reg] : 16'h0000;
  assign add_cin   = run ? carry_reg : 1'b0;

endmodule
